binary_to_octal_decoder: RTL and testbench

BINARY_TO_OCTAL_DECODER -- requirements
Module: binary_to_octal_decoder

---
 rtl/binary_to_octal_decoder_pkg.sv | 11 +
 rtl/binary_to_octal_decoder_hold_counter.sv | 30 +++
 rtl/binary_to_octal_decoder.sv | 104 ++++++++++
 tb/tb_binary_to_octal_decoder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/binary_to_octal_decoder_pkg.sv
// Shared types and constants for the binary-to-octal one-hot decoder.
package binary_to_octal_decoder_pkg;

    localparam int unsigned ONEHOT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/binary_to_octal_decoder_hold_counter.sv
// Saturating hold countdown: loads HOLD_CYCLES-1, decrements to zero, flags zero.
module hold_counter #(
    parameter int unsigned HOLD_CYCLES = 4,
    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_dec,
    input  logic i_clear,
    output logic o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CNT_W'(HOLD_CYCLES - 1);
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/binary_to_octal_decoder.sv
// Decodes an accepted 3-bit code into a registered one-hot word held for
// HOLD_CYCLES cycles; en low during the hold aborts the word.
module binary_to_octal_decoder
    import binary_to_octal_decoder_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                in_valid,
    input  logic [2:0]          in,
    output logic                in_ready,
    output logic [ONEHOT_W-1:0] out,
    output logic                out_valid,
    output logic                done,
    output logic                abort
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ONEHOT_W-1:0] r_out;
    logic [ONEHOT_W-1:0] w_out_nxt;
    logic                r_out_valid;
    logic                w_xfer;
    logic                w_load;
    logic                w_dec;
    logic                w_clear;
    logic                w_zero;
    logic                w_done;
    logic                w_abort;

    hold_counter #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_dec  (w_dec),
        .i_clear(w_clear),
        .o_zero (w_zero)
    );

    assign in_ready = (r_state == IDLE) && en;
    assign w_xfer   = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_clear     = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = HOLD;
                    w_out_nxt   = ONEHOT_W'(1) << in;
                    w_load      = 1'b1;
                end
            end
            HOLD: begin
                // Abort takes priority over completion when both coincide.
                if (!en) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                    w_out_nxt   = '0;
                    w_clear     = 1'b1;
                end else if (w_zero) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                    w_out_nxt   = '0;
                    w_clear     = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_out_nxt   = '0;
                w_clear     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= (w_out_nxt != '0);
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign done      = w_done;
    assign abort     = w_abort;

endmodule

// File: tb/tb_binary_to_octal_decoder.sv
// Scoreboard bench: stimulus queues expected hold-cycle words, monitors compare on out_valid.
module tb_binary_to_octal_decoder;

    typedef struct packed {
        logic [7:0] out;
        logic       done;
        logic       abort;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_en, a_in_valid, a_in_ready, a_out_valid, a_done, a_abort;
    logic [2:0] a_in;
    logic [7:0] a_out;
    logic       b_en, b_in_valid, b_in_ready, b_out_valid, b_done, b_abort;
    logic [2:0] b_in;
    logic [7:0] b_out;

    exp_t qa[$];
    exp_t qb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    binary_to_octal_decoder #(.HOLD_CYCLES(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .in_valid(a_in_valid), .in(a_in),
        .in_ready(a_in_ready), .out(a_out), .out_valid(a_out_valid),
        .done(a_done), .abort(a_abort)
    );

    binary_to_octal_decoder #(.HOLD_CYCLES(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .in_valid(b_in_valid), .in(b_in),
        .in_ready(b_in_ready), .out(b_out), .out_valid(b_out_valid),
        .done(b_done), .abort(b_abort)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (a_out_valid) begin
            if (qa.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL A unexpected word: got out=%0h expected none at %0t", a_out, $time);
            end else begin
                e = qa.pop_front();
                chk("A out", 32'(a_out), 32'(e.out));
                chk("A done", 32'(a_done), 32'(e.done));
                chk("A abort", 32'(a_abort), 32'(e.abort));
                chk("A in_ready in hold", 32'(a_in_ready), 32'd0);
            end
        end else begin
            chk("A idle out", 32'(a_out), 32'd0);
            chk("A idle done", 32'(a_done), 32'd0);
            chk("A idle abort", 32'(a_abort), 32'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_out_valid) begin
            if (qb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL B unexpected word: got out=%0h expected none at %0t", b_out, $time);
            end else begin
                e = qb.pop_front();
                chk("B out", 32'(b_out), 32'(e.out));
                chk("B done", 32'(b_done), 32'(e.done));
                chk("B abort", 32'(b_abort), 32'(e.abort));
            end
        end else begin
            chk("B idle out", 32'(b_out), 32'd0);
            chk("B idle done", 32'(b_done), 32'd0);
            chk("B idle abort", 32'(b_abort), 32'd0);
        end
    end

    // Transfer one code into DUT A; abort_at = hold cycle (1-based) where en is low, 0 = none.
    task automatic send_a(input logic [2:0] code, input logic [7:0] exp_out, input int abort_at);
        int n;
        exp_t e;
        n = (abort_at == 0) ? 4 : abort_at;
        for (int k = 1; k <= n; k++) begin
            e.out   = exp_out;
            e.done  = (abort_at == 0) && (k == 4);
            e.abort = (k == abort_at);
            qa.push_back(e);
        end
        a_in_valid = 1'b1;
        a_in       = code;
        @(posedge clk) #1;
        a_in_valid = 1'b0;
        for (int k = 1; k <= n; k++) begin
            a_en = (k != abort_at);
            @(posedge clk) #1;
        end
        a_en = 1'b1;
    endtask

    logic [7:0] tbl_out [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_en = 1'b0; a_in_valid = 1'b0; a_in = 3'd0;
        b_en = 1'b0; b_in_valid = 1'b0; b_in = 3'd0;
        #2;
        chk("reset out", 32'(a_out), 32'd0);
        chk("reset out_valid", 32'(a_out_valid), 32'd0);
        chk("reset in_ready en low", 32'(a_in_ready), 32'd0);
        a_en = 1'b1;
        b_en = 1'b1;
        #1;
        chk("reset in_ready en high", 32'(a_in_ready), 32'd1);
        @(posedge clk) #1;
        @(posedge clk) #1;
        rst_n = 1'b1;

        // Scenario 1: all codes, each held 4 cycles with one zero cycle between.
        for (int c = 0; c < 8; c++) begin
            send_a(3'(c), tbl_out[c], 0);
        end

        // Scenario 2: minimum hold on DUT B, done in the only valid cycle.
        qb.push_back('{out: 8'h20, done: 1'b1, abort: 1'b0});
        b_in_valid = 1'b1;
        b_in = 3'd5;
        @(posedge clk) #1;
        b_in_valid = 1'b0;
        @(posedge clk) #1;

        // Scenario 3: en low in the 2nd hold cycle.
        send_a(3'd3, 8'h08, 2);
        // Scenario 4: en low when counter is 0.
        send_a(3'd1, 8'h02, 4);

        // Scenario 5: code 6 offered during hold of code 2 is not accepted until idle.
        for (int k = 1; k <= 4; k++) qa.push_back('{out: 8'h04, done: (k == 4), abort: 1'b0});
        for (int k = 1; k <= 4; k++) qa.push_back('{out: 8'h40, done: (k == 4), abort: 1'b0});
        a_in_valid = 1'b1;
        a_in = 3'd2;
        @(posedge clk) #1;
        a_in = 3'd6;
        repeat (4) @(posedge clk) #1;
        chk("S5 in_ready after hold", 32'(a_in_ready), 32'd1);
        @(posedge clk) #1;
        a_in_valid = 1'b0;
        repeat (4) @(posedge clk) #1;

        // Scenario 6: asynchronous reset between edges in the 2nd hold cycle.
        qa.push_back('{out: 8'h01, done: 1'b0, abort: 1'b0});
        a_in_valid = 1'b1;
        a_in = 3'd0;
        @(posedge clk) #1;
        a_in_valid = 1'b0;
        @(posedge clk) #3;
        chk("S6 out before reset", 32'(a_out), 32'h01);
        rst_n = 1'b0;
        #1;
        chk("S6 async out", 32'(a_out), 32'd0);
        chk("S6 async out_valid", 32'(a_out_valid), 32'd0);
        chk("S6 async done", 32'(a_done), 32'd0);
        chk("S6 async abort", 32'(a_abort), 32'd0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) qa.push_back('{out: 8'h80, done: (k == 4), abort: 1'b0});
        a_in_valid = 1'b1;
        a_in = 3'd7;
        @(posedge clk) #1;
        a_in_valid = 1'b0;
        chk("S6 latency out", 32'(a_out), 32'h80);
        repeat (4) @(posedge clk) #1;

        for (int t = 0; t < 20 && (qa.size() != 0 || qb.size() != 0); t++) @(posedge clk) #1;
        chk("A queue drained", 32'(qa.size()), 32'd0);
        chk("B queue drained", 32'(qb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
